// File: rtl/pulse_tracer_mc_if.sv
// Bus bundle for pulse_tracer_mc: raw inputs, filter controls and filtered outputs.
// The glitch_clr/glitch_flag/glitch_total members exist only when GLITCH_COUNT_EN is defined.
interface pulse_tracer_mc_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 4
);
  logic [CHANNELS-1:0] noisy_in;
  logic [CNT_W-1:0]    stable_cnt;
  logic [1:0]          edge_mode;
  logic [CHANNELS-1:0] clean_out;
  logic [CHANNELS-1:0] pulse_out;
`ifdef GLITCH_COUNT_EN
  logic                glitch_clr;
  logic [CHANNELS-1:0] glitch_flag;
  logic [7:0]          glitch_total;
`endif

  modport master (
    output noisy_in,
    output stable_cnt,
    output edge_mode,
    input  clean_out,
    input  pulse_out
`ifdef GLITCH_COUNT_EN
    ,
    output glitch_clr,
    input  glitch_flag,
    input  glitch_total
`endif
  );

  modport slave (
    input  noisy_in,
    input  stable_cnt,
    input  edge_mode,
    output clean_out,
    output pulse_out
`ifdef GLITCH_COUNT_EN
    ,
    input  glitch_clr,
    output glitch_flag,
    output glitch_total
`endif
  );
endinterface

// File: rtl/pulse_tracer_mc.sv
// Multi-channel input conditioner: synchroniser, programmable glitch filter, edge-pulse generator.
// Optional GLITCH_COUNT_EN adds sticky per-channel glitch flags and a saturating glitch counter.
module pulse_tracer_mc #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  pulse_tracer_mc_if.slave  bus
);

  logic [CHANNELS-1:0]             sync_r [SYNC_STAGES];
  logic [CHANNELS-1:0]             synced_s;
  logic [CHANNELS-1:0]             clean_r;
  logic [CHANNELS-1:0]             clean_nxt_s;
  logic [CHANNELS-1:0]             pulse_r;
  logic [CHANNELS-1:0]             pulse_nxt_s;
  logic [CHANNELS-1:0]             edge_ev_s;
  logic [CHANNELS-1:0][CNT_W-1:0]  cnt_r;
  logic [CHANNELS-1:0][CNT_W-1:0]  cnt_nxt_s;
`ifdef GLITCH_COUNT_EN
  localparam int SUM_W = 9 + $clog2(CHANNELS + 1);
  logic [CHANNELS-1:0]             glitch_ev_s;
  logic [CHANNELS-1:0]             glitch_flag_r;
  logic [7:0]                      glitch_total_r;
  logic [7:0]                      glitch_total_nxt_s;
  logic [SUM_W-1:0]                glitch_sum_s;
`endif

  // rising says which level the channel is settling to; mode 11 suppresses every pulse
  function automatic logic dir_match(input logic [1:0] mode, input logic rising);
    logic m;
    case (mode)
      2'b00:   m = rising;
      2'b01:   m = ~rising;
      2'b10:   m = 1'b1;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

`ifdef GLITCH_COUNT_EN
  function automatic logic [SUM_W-1:0] popcnt(input logic [CHANNELS-1:0] v);
    logic [SUM_W-1:0] c;
    c = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      c = c + SUM_W'(v[i]);
    end
    return c;
  endfunction
`endif

  assign synced_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain, one row of flops per stage covering all channels
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
    end else begin
      sync_r[0] <= bus.noisy_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Qualification: counter never passes stable_cnt, so it cannot wrap
  always_comb begin
    clean_nxt_s = clean_r;
    cnt_nxt_s   = cnt_r;
    pulse_nxt_s = '0;
    edge_ev_s   = '0;
`ifdef GLITCH_COUNT_EN
    glitch_ev_s = '0;
`endif
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (synced_s[ch] != clean_r[ch]) begin
        if (cnt_r[ch] >= bus.stable_cnt) begin
          clean_nxt_s[ch] = synced_s[ch];
          cnt_nxt_s[ch]   = '0;
          edge_ev_s[ch]   = 1'b1;
        end else begin
          cnt_nxt_s[ch]   = cnt_r[ch] + CNT_W'(1);
        end
      end else begin
        cnt_nxt_s[ch] = '0;
`ifdef GLITCH_COUNT_EN
        glitch_ev_s[ch] = (cnt_r[ch] != '0);
`endif
      end
      pulse_nxt_s[ch] = edge_ev_s[ch] & dir_match(bus.edge_mode, synced_s[ch]);
    end
  end

  // Filter state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clean_r <= '0;
      pulse_r <= '0;
      cnt_r   <= '0;
    end else begin
      clean_r <= clean_nxt_s;
      pulse_r <= pulse_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign bus.clean_out = clean_r;
  assign bus.pulse_out = pulse_r;

`ifdef GLITCH_COUNT_EN
  // Saturating add of this cycle's glitch events; wide enough that the sum cannot overflow
  always_comb begin
    glitch_sum_s = {{(SUM_W-8){1'b0}}, glitch_total_r} + popcnt(glitch_ev_s);
    if (glitch_sum_s > SUM_W'(255)) begin
      glitch_total_nxt_s = 8'hFF;
    end else begin
      glitch_total_nxt_s = glitch_sum_s[7:0];
    end
  end

  // Glitch bookkeeping; clear takes priority over same-cycle events
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      glitch_flag_r  <= '0;
      glitch_total_r <= 8'h00;
    end else if (bus.glitch_clr) begin
      glitch_flag_r  <= '0;
      glitch_total_r <= 8'h00;
    end else begin
      glitch_flag_r  <= glitch_flag_r | glitch_ev_s;
      glitch_total_r <= glitch_total_nxt_s;
    end
  end

  assign bus.glitch_flag  = glitch_flag_r;
  assign bus.glitch_total = glitch_total_r;
`endif

endmodule
